draw_number_ctrl: RTL and testbench

DRAW_NUMBER_CTRL -- requirements
Module: draw_number_ctrl

---
 rtl/draw_number_ctrl_pkg.sv | 37 +++
 rtl/draw_number_ctrl_bin2bcd_seq.sv | 45 ++++
 rtl/draw_number_ctrl.sv | 155 +++++++++++++++
 tb/tb_draw_number_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_number_ctrl_pkg.sv
// Shared VGA text constants: number-drawer FSM encoding, glyph pitch, ASCII base
// and the double-dabble helpers used by the sequential BCD converter.
package draw_number_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int         GLYPH_PITCH = 6;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int BIN_W      = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = 5;

  // Add 3 to every nibble >= 5 ahead of the next left shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Digit count 0 behaves as 1, anything above 5 as 5.
  function automatic logic [2:0] clamp_ndig(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'd5)  return 3'd5;
    return n;
  endfunction

endpackage

// File: rtl/draw_number_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits, one shift per cycle.
// valid pulses for one cycle once bcd holds the final result; bcd then holds until the next start.
module bin2bcd_seq
  import draw_number_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             valid,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      valid <= 1'b0;
      bcd   <= '0;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      valid <= 1'b0;
      if (start && !busy) begin
        // The adjust step on a cleared BCD register is a no-op, so the load
        // edge also performs shift 1; the last shift lands one cycle earlier.
        bcd   <= {{(BCD_W-1){1'b0}}, bin[BIN_W-1]};
        shreg <= bin << 1;
        cnt   <= CNT_W'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        {bcd, shreg} <= {bcd_adjust(bcd), shreg} << 1;
        cnt          <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_W - 1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/draw_number_ctrl.sv
// Draws an unsigned 16-bit value as 1..5 decimal glyphs through a single
// character-drawer port, left to right, with optional leading-zero blanking and right-edge clipping.
module draw_number_ctrl
  import draw_number_ctrl_pkg::*;
#(
  parameter int PIXEL_X_WIDTH   = 10,
  parameter int PIXEL_Y_WIDTH   = 9,
  parameter int PIXEL_X_MAX     = 639,
  parameter int COLOR_ID_WIDTH  = 8,
  parameter int CHAR_CODE_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                value,
  input  logic [2:0]                 ndig,
  input  logic                       blank_lz,
  input  logic [PIXEL_X_WIDTH-1:0]   x,
  input  logic [PIXEL_Y_WIDTH-1:0]   y,
  input  logic [3:0]                 size,
  input  logic [COLOR_ID_WIDTH-1:0]  fg,
  input  logic [COLOR_ID_WIDTH-1:0]  bg,
  output logic                       busy,
  output logic                       done,
  output logic                       clip,
  output logic [PIXEL_X_WIDTH-1:0]   cx,
  output logic [PIXEL_Y_WIDTH-1:0]   cy,
  output logic [CHAR_CODE_WIDTH-1:0] ccode,
  output logic [3:0]                 csize,
  output logic [1:0]                 cmode,
  output logic [COLOR_ID_WIDTH-1:0]  cfg,
  output logic [COLOR_ID_WIDTH-1:0]  cbg,
  output logic                       cvld,
  input  logic                       cdone
);

  localparam int CXW = PIXEL_X_WIDTH + 4;

  typedef struct packed {
    logic                      blank_lz;
    logic [PIXEL_Y_WIDTH-1:0]  y;
    logic [3:0]                size;
    logic [COLOR_ID_WIDTH-1:0] fg;
    logic [COLOR_ID_WIDTH-1:0] bg;
  } req_t;

  state_t           state;
  req_t             req;
  logic [2:0]       idx;
  logic [CXW-1:0]   cx_acc;
  logic             seen_nz;

  logic             cvt_start, cvt_busy, cvt_valid;
  logic [BCD_W-1:0] cvt_bcd;

  logic             accept;
  logic [6:0]       pitch;
  logic [3:0]       digit;
  logic [CXW-1:0]   char_end;
  logic             over;
  logic             blank;

  assign accept    = (state == IDLE) && start && !cvt_busy;
  assign cvt_start = accept;

  assign pitch    = 7'(GLYPH_PITCH) * ({3'b000, req.size} + 7'd1);
  assign digit    = cvt_bcd[4*idx +: 4];
  assign char_end = cx_acc + CXW'(pitch) - CXW'(1);
  assign over     = char_end > CXW'(PIXEL_X_MAX);
  // Only zeros left of the first nonzero digit blank; the units digit always draws.
  assign blank    = req.blank_lz && !seen_nz && (digit == 4'd0) && (idx != 3'd0);

  assign cmode = 2'b10;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cvt_start),
    .bin   (value),
    .busy  (cvt_busy),
    .valid (cvt_valid),
    .bcd   (cvt_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req     <= '0;
      idx     <= '0;
      cx_acc  <= '0;
      seen_nz <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      clip    <= 1'b0;
      cvld    <= 1'b0;
      cx      <= '0;
      cy      <= '0;
      ccode   <= '0;
      csize   <= '0;
      cfg     <= '0;
      cbg     <= '0;
    end else begin
      done <= 1'b0;
      cvld <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req     <= '{blank_lz: blank_lz, y: y, size: size, fg: fg, bg: bg};
          idx     <= clamp_ndig(ndig) - 3'd1;
          cx_acc  <= CXW'(x);
          seen_nz <= 1'b0;
          clip    <= 1'b0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: if (cvt_valid) state <= ISSUE;
        ISSUE: begin
          if (blank) begin
            idx    <= idx - 3'd1;
            cx_acc <= cx_acc + CXW'(pitch);
          end else if (over) begin
            clip  <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            cvld    <= 1'b1;
            cx      <= cx_acc[PIXEL_X_WIDTH-1:0];
            cy      <= req.y;
            ccode   <= CHAR_CODE_WIDTH'(ASCII_ZERO) + CHAR_CODE_WIDTH'(digit);
            csize   <= req.size;
            cfg     <= req.fg;
            cbg     <= req.bg;
            seen_nz <= 1'b1;
            cx_acc  <= cx_acc + CXW'(pitch);
            state   <= WAIT;
          end
        end
        WAIT: if (cdone) begin
          if (idx == 3'd0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx   <= idx - 3'd1;
            state <= ISSUE;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_number_ctrl.sv
// Vector table of number requests checked against a decimal reference model via a
// character scoreboard, plus a hand-written abort/reset sequence.
module tb_draw_number_ctrl;

  localparam int DLY = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic [2:0]  ndig;
  logic        blank_lz;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [3:0]  size;
  logic [7:0]  fg, bg;
  logic        busy, done, clip;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic [7:0]  ccode;
  logic [3:0]  csize;
  logic [1:0]  cmode;
  logic [7:0]  cfg, cbg;
  logic        cvld;
  logic        cdone;

  always #5 clk = ~clk;

  draw_number_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .ndig(ndig),
    .blank_lz(blank_lz), .x(x), .y(y), .size(size), .fg(fg), .bg(bg),
    .busy(busy), .done(done), .clip(clip), .cx(cx), .cy(cy), .ccode(ccode),
    .csize(csize), .cmode(cmode), .cfg(cfg), .cbg(cbg), .cvld(cvld), .cdone(cdone)
  );

  typedef struct {
    int value; int ndig; bit blank; int x; int y; int size; int fg; int bg;
    int exp_n; bit exp_clip;
  } vec_t;

  typedef struct { int cx; int cy; int code; int size; int fg; int bg; } exp_t;

  exp_t sbq[$];
  vec_t vecs[14];

  int tests = 0, fails = 0;
  int cyc = 0;
  int n_cvld = 0, n_done = 0;
  bit last_clip = 1'b0;
  bit outstanding = 1'b0;
  int cd_cnt = 0;
  bit drawer_en = 1'b1;
  bit cdone_req = 1'b0;
  int first_cvld_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: digits by repeated division, placement/blank/clip rules applied per glyph.
  task automatic push_model(input vec_t v);
    int d[5];
    int n, vv, px, pitch, dig, i;
    bit seen;
    exp_t e;
    n = (v.ndig == 0) ? 1 : (v.ndig > 5) ? 5 : v.ndig;
    vv = v.value;
    for (int j = 0; j < 5; j++) begin d[j] = vv % 10; vv = vv / 10; end
    pitch = 6 * (v.size + 1);
    px = v.x;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      i = n - 1 - k;
      dig = d[i];
      if (v.blank && !seen && dig == 0 && i != 0) begin
        px += pitch;
        continue;
      end
      if (dig != 0) seen = 1'b1;
      if (px + pitch - 1 > 639) break;
      e.cx = px; e.cy = v.y; e.code = 48 + dig; e.size = v.size; e.fg = v.fg; e.bg = v.bg;
      sbq.push_back(e);
      px += pitch;
    end
  endtask

  // Monitor and character-drawer model, all on the falling edge.
  initial begin
    exp_t e;
    cdone = 1'b0;
    forever begin
      @(negedge clk);
      cdone = 1'b0;
      if (cdone_req) begin cdone = 1'b1; cdone_req = 1'b0; end
      if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin cdone = 1'b1; outstanding = 1'b0; end
      end
      if (cvld) begin
        n_cvld++;
        if (first_cvld_cyc < 0) first_cvld_cyc = cyc;
        check("single_outstanding", outstanding, 0);
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_cvld: got code %0h at cx %0d, expected none", ccode, cx);
        end else begin
          e = sbq.pop_front();
          check("cx", cx, e.cx);
          check("cy", cy, e.cy);
          check("ccode", ccode, e.code);
          check("csize", csize, e.size);
          check("cfg", cfg, e.fg);
          check("cbg", cbg, e.bg);
          check("cmode", cmode, 2);
        end
        outstanding = 1'b1;
        if (drawer_en) cd_cnt = DLY;
      end
      if (done) begin n_done++; last_clip = clip; end
    end
  end

  task automatic drive_req(input vec_t v);
    value = 16'(v.value); ndig = 3'(v.ndig); blank_lz = v.blank;
    x = 10'(v.x); y = 9'(v.y); size = 4'(v.size); fg = 8'(v.fg); bg = 8'(v.bg);
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit chk_lat);
    int d0, c0, start_cyc;
    d0 = n_done; c0 = n_cvld; first_cvld_cyc = -1;
    @(negedge clk);
    drive_req(v);
    start = 1'b1;
    push_model(v);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    check($sformatf("v%0d_busy_after_start", id), busy, 1);
    for (int c = 0; c < 2000 && n_done == d0; c++) @(posedge clk);
    if (n_done == d0) begin
      tests++; fails++;
      $display("FAIL v%0d_done_timeout: got no done, expected done within 2000 cycles", id);
    end
    @(negedge clk);
    @(negedge clk);
    check($sformatf("v%0d_done_pulses", id), n_done - d0, 1);
    check($sformatf("v%0d_cvld_count", id), n_cvld - c0, v.exp_n);
    check($sformatf("v%0d_clip", id), last_clip, v.exp_clip);
    check($sformatf("v%0d_sb_left", id), sbq.size(), 0);
    check($sformatf("v%0d_busy_idle", id), busy, 0);
    if (chk_lat) check($sformatf("v%0d_first_cvld_latency", id), first_cvld_cyc - start_cyc, 17);
    sbq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0;
    vecs[0]  = '{1234,  4, 0, 100, 50,  0,  15, 1,   4, 0};
    vecs[1]  = '{7,     5, 1, 10,  20,  1,  2,  3,   1, 0};
    vecs[2]  = '{0,     3, 1, 0,   0,   2,  4,  5,   1, 0};
    vecs[3]  = '{99999 & 16'hffff, 5, 0, 620, 7, 0, 6, 7, 3, 1};
    vecs[4]  = '{65535, 3, 0, 200, 100, 3,  8,  9,   3, 0};
    vecs[5]  = '{42,    0, 0, 5,   5,   0,  1,  0,   1, 0};
    vecs[6]  = '{42,    7, 1, 0,   0,   0,  1,  0,   2, 0};
    vecs[7]  = '{5,     2, 0, 630, 0,   0,  1,  0,   1, 1};
    vecs[8]  = '{100,   3, 1, 300, 479, 0,  170, 85, 3, 0};
    vecs[9]  = '{123,   2, 0, 0,   0,   0,  1,  2,   2, 0};
    vecs[10] = '{31415, 5, 0, 500, 0,   1,  3,  4,   5, 0};
    vecs[11] = '{9,     1, 0, 635, 0,   0,  1,  0,   0, 1};
    vecs[12] = '{77,    2, 0, 634, 0,   0,  1,  0,   1, 1};
    vecs[13] = '{12345, 5, 0, 0,   0,   15, 255, 0,  5, 0};
    // 99999 exceeds 16 bits: the request carries 99999 mod 65536 = 34463, still 5 digits.

    rst = 1'b1; start = 1'b0;
    drive_req(vecs[0]);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clip", clip, 0);
    check("rst_cvld", cvld, 0);
    check("rst_cx", cx, 0);
    check("rst_ccode", ccode, 0);
    check("rst_cmode", cmode, 2);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i, i == 0);

    // Abort: second start during WAIT is ignored, reset kills the request, late cdone is dropped.
    drawer_en = 1'b0;
    c0 = n_cvld; d0 = n_done;
    @(negedge clk);
    drive_req(vecs[0]);
    start = 1'b1;
    push_model(vecs[0]);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && n_cvld == c0; c++) @(posedge clk);
    check("abort_first_cvld", n_cvld - c0, 1);
    @(negedge clk);
    drive_req(vecs[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_held", busy, 1);
    check("abort_no_extra_cvld", n_cvld - c0, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_busy_cleared", busy, 0);
    check("abort_cvld_cleared", cvld, 0);
    sbq.delete();
    outstanding = 1'b0;
    cdone_req = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    check("abort_late_cdone_no_cvld", n_cvld - c0, 1);
    check("abort_idle_busy", busy, 0);
    drawer_en = 1'b1;

    run_vec(vecs[4], 100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
